user_req_split: RTL and testbench
=================================

USER_REQ_SPLIT -- requirements
Module: user_req_split

Interface
REQ-001 SHALL have parameter MAX_XFER, default 4096, meaning the chunk size and alignment in bytes; it must be a power of two and at least 64.
REQ-002 SHALL have parameter ID_REG, default 0, meaning the vFPGA index; it is carried only for debug and does not alter the data path.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_req, metaIntf.s, req_t: the parent request from the local read or write mux output.
REQ-006 SHALL have port m_req, metaIntf.m, req_t: the chunk request toward the host/card DMA path.
REQ-007 SHALL have port busy, output, 1 bit: high while a parent request is held.

Function
REQ-008 SHALL implement the state machine IDLE -> SPLIT -> IDLE.
REQ-009 In IDLE, s_req.ready SHALL be 1 and m_req.valid 0.
REQ-010 In SPLIT, s_req.ready SHALL be 0.
REQ-011 On an s_req handshake in IDLE, the block SHALL register the whole request and take vaddr as the current address and len as the remaining length.
REQ-012 On that handshake the state SHALL go to SPLIT.
REQ-013 The first chunk SHALL be valid on the cycle after acceptance.
REQ-014 Chunk length SHALL be min(remaining, MAX_XFER - (addr mod MAX_XFER)), so no chunk crosses a MAX_XFER-aligned boundary.
REQ-015 The chunk length SHALL be computed at len field width with no truncation.
REQ-016 Chunk vaddr SHALL be the current address.
REQ-017 All other req_t fields SHALL be copied unchanged from the parent, except last.
REQ-018 Chunk last SHALL be parent.last AND (this is the final chunk).
REQ-019 On each m_req handshake, addr SHALL advance by the chunk length and remaining SHALL decrease by the chunk length.
REQ-020 When remaining reaches 0, the state SHALL return to IDLE.
REQ-021 In SPLIT, one chunk SHALL be issued per cycle while m_req.ready is high.
REQ-022 Sustained throughput SHALL be N chunks per N+1 cycles per parent (one IDLE bubble).
REQ-023 While m_req.valid is high and m_req.ready is low, m_req.data SHALL remain stable.
REQ-024 m_req.valid SHALL not drop until the handshake.
REQ-025 A parent with len = 0 SHALL produce exactly one chunk with len 0, the parent vaddr and last = parent.last.
REQ-026 An address that wraps at the top of vaddr width SHALL wrap modulo 2^width, with no error.
REQ-027 busy SHALL equal (state == SPLIT).
REQ-028 m_req.data SHALL be driven from registers only, with no combinational path from s_req to m_req.

Reset
REQ-029 While areset is high, the state SHALL be IDLE, m_req.valid 0, busy 0, and the address and remaining registers 0.
REQ-030 s_req.ready SHALL be 0 while areset is high.
REQ-031 Reset asserted mid-split SHALL discard the held parent and any unissued chunks.
REQ-032 After reset is released, the first accepted request SHALL be split from scratch.
REQ-033 Outputs SHALL take their reset values on the first clock edge with areset high.

Structure
REQ-034 req_t, the field widths and the MAX_XFER default SHALL live in lynxTypes.
REQ-035 A helper function computing bytes-to-boundary SHALL be added to lynxTypes.
REQ-036 The block SHALL be one module with no sub-module.
REQ-037 It SHALL be instantiated once per direction (rd and wr) directly downstream of the request mux local outputs.

Verification
REQ-038 Bench SHALL drive vaddr 0x1000, len 0x3000, last 1, MAX_XFER 4096, ready held 1 -> three chunks (0x1000/0x1000, 0x2000/0x1000, 0x3000/0x1000) on consecutive cycles, last=1 only on the third.
REQ-039 Bench SHALL drive vaddr 0x0F80, len 0x200 -> chunks (0x0F80/0x80) and (0x1000/0x180).
REQ-040 Bench SHALL drive len 0 at vaddr 0x40 -> a single chunk 0x40/0 with last equal to the parent's last; the block returns to IDLE.
REQ-041 Bench SHALL toggle m_req.ready at random on a 5-chunk request -> data stable while stalled, exactly 5 handshakes, and s_req.ready 0 until the final handshake completes.
REQ-042 Bench SHALL assert areset after the second of four chunks -> no further chunks, busy 0, and the next request (vaddr 0x0, len 0x10) yields one chunk 0x0/0x10.
REQ-043 Bench SHALL issue back-to-back parents each of len 0x1000, aligned -> one chunk per parent, with a one-cycle bubble between them.

Source files
------------

// File: rtl/lynxTypes.sv
// rtl/lynxTypes.sv - shared request type, field widths and split helper
package lynxTypes;

  localparam int VADDR_BITS   = 48;
  localparam int LEN_BITS     = 28;
  localparam int OPCODE_BITS  = 5;
  localparam int STRM_BITS    = 2;
  localparam int DEST_BITS    = 4;
  localparam int PID_BITS     = 6;
  localparam int MAX_XFER_DEF = 4096;

  typedef struct packed {
    logic [OPCODE_BITS-1:0] opcode;
    logic [STRM_BITS-1:0]   strm;
    logic [DEST_BITS-1:0]   dest;
    logic [PID_BITS-1:0]    pid;
    logic [VADDR_BITS-1:0]  vaddr;
    logic [LEN_BITS-1:0]    len;
    logic                   last;
  } req_t;

  localparam int REQ_BITS = $bits(req_t);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

  // Distance from addr to the next xfer-aligned boundary; xfer is a power of two,
  // so the result lies in 1..xfer and always fits the len width.
  function automatic logic [LEN_BITS-1:0] bytes_to_boundary(
    input logic [VADDR_BITS-1:0] addr,
    input logic [LEN_BITS-1:0]   xfer
  );
    logic [LEN_BITS-1:0] off;
    off = LEN_BITS'(addr & VADDR_BITS'(xfer - 1'b1));
    return xfer - off;
  endfunction

endpackage

// File: rtl/user_req_split.sv
// rtl/user_req_split.sv - splits a parent request into MAX_XFER-aligned chunk requests
module user_req_split
  import lynxTypes::*;
#(
  parameter int MAX_XFER = MAX_XFER_DEF,
  parameter int ID_REG   = 0
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                s_req_valid,
  output logic                s_req_ready,
  input  logic [REQ_BITS-1:0] s_req_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [REQ_BITS-1:0] m_req_data,
  output logic                busy
);

  localparam logic [LEN_BITS-1:0] XFER = LEN_BITS'(MAX_XFER);
  // A misconfigured instance never accepts a request, which makes the error obvious.
  localparam logic CFG_OK = (MAX_XFER >= 64) && ((MAX_XFER & (MAX_XFER - 1)) == 0) &&
                            (ID_REG >= 0);

  split_state_t          r_state;
  req_t                  r_parent;
  req_t                  r_out;
  logic [VADDR_BITS-1:0] r_addr;
  logic [LEN_BITS-1:0]   r_rem;

  split_state_t          w_state_n;
  req_t                  w_s_req;
  req_t                  w_parent_n;
  req_t                  w_chunk;
  logic [VADDR_BITS-1:0] w_addr_n;
  logic [LEN_BITS-1:0]   w_rem_n;
  logic [LEN_BITS-1:0]   w_btb;
  logic [LEN_BITS-1:0]   w_clen;
  logic                  w_load;
  logic                  w_final;

  assign w_s_req     = s_req_data;
  assign w_final     = (r_out.len == r_rem);
  assign s_req_ready = CFG_OK && (r_state == ST_IDLE) && !areset;
  assign m_req_valid = (r_state == ST_SPLIT);
  assign busy        = (r_state == ST_SPLIT);
  assign m_req_data  = r_out;

  always_comb begin
    w_state_n  = r_state;
    w_parent_n = r_parent;
    w_addr_n   = r_addr;
    w_rem_n    = r_rem;
    w_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_req_valid && s_req_ready) begin
          w_state_n  = ST_SPLIT;
          w_parent_n = w_s_req;
          w_addr_n   = w_s_req.vaddr;
          w_rem_n    = w_s_req.len;
          w_load     = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (m_req_ready) begin
          if (w_final) begin
            w_state_n = ST_IDLE;
          end else begin
            w_addr_n = r_addr + VADDR_BITS'(r_out.len);
            w_rem_n  = r_rem - r_out.len;
            w_load   = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // The chunk is built from next-cycle address/remaining so it lands in a register.
    w_btb         = bytes_to_boundary(w_addr_n, XFER);
    w_clen        = (w_rem_n < w_btb) ? w_rem_n : w_btb;
    w_chunk       = w_parent_n;
    w_chunk.vaddr = w_addr_n;
    w_chunk.len   = w_clen;
    w_chunk.last  = w_parent_n.last && (w_clen == w_rem_n);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_parent <= '0;
      r_out    <= '0;
      r_addr   <= '0;
      r_rem    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_parent <= w_parent_n;
      r_addr   <= w_addr_n;
      r_rem    <= w_rem_n;
      if (w_load) begin
        r_out <= w_chunk;
      end
    end
  end

endmodule

// File: tb/tb_user_req_split.sv
// tb/tb_user_req_split.sv - directed self-checking bench for user_req_split
module tb_user_req_split;
  import lynxTypes::*;

  logic                aclk;
  logic                areset;
  logic                s_req_valid;
  logic                s_req_ready;
  logic [REQ_BITS-1:0] s_req_data;
  logic                m_req_valid;
  logic                m_req_ready;
  logic [REQ_BITS-1:0] m_req_data;
  logic                busy;

  req_t m_view;
  req_t s_drv;
  int   checks;
  int   errors;

  assign m_view     = m_req_data;
  assign s_req_data = s_drv;

  user_req_split #(.MAX_XFER(4096), .ID_REG(0)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_req_data  (s_req_data),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_data  (m_req_data),
    .busy        (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_chunk(input string tag, input logic [63:0] addr, input logic [63:0] len,
                           input logic last, input logic [16:0] side);
    check({tag, ".valid"}, 64'(m_req_valid), 64'd1);
    check({tag, ".vaddr"}, 64'(m_view.vaddr), addr);
    check({tag, ".len"},   64'(m_view.len), len);
    check({tag, ".last"},  64'(m_view.last), 64'(last));
    check({tag, ".side"},  64'({m_view.opcode, m_view.strm, m_view.dest, m_view.pid}), 64'(side));
    check({tag, ".s_ready"}, 64'(s_req_ready), 64'd0);
    check({tag, ".busy"},  64'(busy), 64'd1);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".valid"},   64'(m_req_valid), 64'd0);
    check({tag, ".busy"},    64'(busy), 64'd0);
    check({tag, ".s_ready"}, 64'(s_req_ready), 64'd1);
  endtask

  task automatic send(input logic [47:0] addr, input logic [27:0] len, input logic last,
                      input logic [16:0] side);
    int n;
    n = 0;
    while (!s_req_ready && n < 20) begin
      step();
      n++;
    end
    check("send.ready_wait", 64'(s_req_ready), 64'd1);
    {s_drv.opcode, s_drv.strm, s_drv.dest, s_drv.pid} = side;
    s_drv.vaddr = addr;
    s_drv.len   = len;
    s_drv.last  = last;
    s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    s_drv       = '0;
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;
    checks      = 0;
    errors      = 0;
    areset      = 1'b1;
    s_req_valid = 1'b0;
    s_drv       = '0;
    m_req_ready = 1'b1;

    step();
    check("rst.valid",   64'(m_req_valid), 64'd0);
    check("rst.busy",    64'(busy), 64'd0);
    check("rst.s_ready", 64'(s_req_ready), 64'd0);
    areset = 1'b0;
    step();
    chk_idle("post_rst");

    // three aligned chunks, ready held high
    send(48'h1000, 28'h3000, 1'b1, 17'h0A5C3);
    chk_chunk("t1.c0", 64'h1000, 64'h1000, 1'b0, 17'h0A5C3); step();
    chk_chunk("t1.c1", 64'h2000, 64'h1000, 1'b0, 17'h0A5C3); step();
    chk_chunk("t1.c2", 64'h3000, 64'h1000, 1'b1, 17'h0A5C3); step();
    chk_idle("t1.end");

    // unaligned start crossing one boundary
    send(48'h0F80, 28'h200, 1'b1, 17'h1F00F);
    chk_chunk("t2.c0", 64'h0F80, 64'h80, 1'b0, 17'h1F00F); step();
    chk_chunk("t2.c1", 64'h1000, 64'h180, 1'b1, 17'h1F00F); step();
    chk_idle("t2.end");

    // zero length, with parent last set and clear
    send(48'h40, 28'h0, 1'b1, 17'h00001);
    chk_chunk("t3a.c0", 64'h40, 64'h0, 1'b1, 17'h00001); step();
    chk_idle("t3a.end");
    send(48'h40, 28'h0, 1'b0, 17'h00002);
    chk_chunk("t3b.c0", 64'h40, 64'h0, 1'b0, 17'h00002); step();
    chk_idle("t3b.end");

    // address wraps at the top of the vaddr width
    send(48'hFFFF_FFFF_F800, 28'h1000, 1'b1, 17'h12345);
    chk_chunk("wrap.c0", 64'hFFFF_FFFF_F800, 64'h800, 1'b0, 17'h12345); step();
    chk_chunk("wrap.c1", 64'h0, 64'h800, 1'b1, 17'h12345); step();
    chk_idle("wrap.end");

    // five chunks with random back-pressure
    m_req_ready = 1'b0;
    send(48'h0, 28'h5000, 1'b1, 17'h0BEEF);
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 200) begin
      chk_chunk("t4.hold", 64'(idx) * 64'h1000, 64'h1000, idx == 4, 17'h0BEEF);
      rdy = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      m_req_ready = rdy;
      step();
      if (rdy) idx++;
      cyc++;
    end
    check("t4.handshakes", 64'(idx), 64'd5);
    m_req_ready = 1'b1;
    chk_idle("t4.end");
    step();
    check("t4.no_extra", 64'(m_req_valid), 64'd0);

    // reset after two of four chunks
    send(48'h0, 28'h4000, 1'b1, 17'h00777);
    chk_chunk("t5.c0", 64'h0,    64'h1000, 1'b0, 17'h00777); step();
    chk_chunk("t5.c1", 64'h1000, 64'h1000, 1'b0, 17'h00777); step();
    areset = 1'b1;
    step();
    check("t5.rst.valid",   64'(m_req_valid), 64'd0);
    check("t5.rst.busy",    64'(busy), 64'd0);
    check("t5.rst.s_ready", 64'(s_req_ready), 64'd0);
    areset = 1'b0;
    step();
    chk_idle("t5.after0");
    step();
    chk_idle("t5.after1");
    send(48'h0, 28'h10, 1'b1, 17'h00042);
    chk_chunk("t5.new", 64'h0, 64'h10, 1'b1, 17'h00042); step();
    chk_idle("t5.end");

    // back-to-back aligned parents: one chunk each, one bubble between
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        s_drv.vaddr = 48'h4000;
        s_drv.len   = 28'h1000;
        s_drv.last  = 1'b1;
        s_req_valid = 1'b1;
      end
      step();
      chk_chunk($sformatf("t6.p%0d", p), 64'h4000 + 64'(p) * 64'h1000, 64'h1000, 1'b1, 17'h0);
      if (p < 2) begin
        s_drv.vaddr = 48'h4000 + 48'(p + 1) * 48'h1000;
      end else begin
        s_req_valid = 1'b0;
        s_drv       = '0;
      end
      step();
      chk_idle($sformatf("t6.bubble%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
